// File: rtl/rgb_lookup_arbiter.sv
// rgb_lookup_arbiter
// Shares one registered RGB lookup converter between two requesters. A round-robin arbiter
// accepts one valid/ready request at a time. It drives the converter's enable and colour for the
// lookup window, captures the rgb result and returns it on a per-requester valid/ready response.
//
// Ports:
//   clk, rst_n          clock (rising edge), asynchronous active-low reset
//   req_valid_i[1:0]    request valid, bit i = requester i
//   req_colour0_i/1_i   3-bit colour code from requester 0 / 1
//   req_ready_o[1:0]    request accepted this cycle (one-hot or zero)
//   rsp_valid_o[1:0]    response valid for requester i (one-hot or zero)
//   rsp_ready_i[1:0]    requester i takes the response
//   rsp_rgb_o[23:0]     looked-up colour, meaningful while rsp_valid_o != 0
//   busy_o              transaction in flight (LOOKUP or RESP)
//   conv_colour_o       colour to converter
//   conv_enable_o       enable to converter
//   conv_rgb_i          rgb from converter
module rgb_lookup_arbiter #(
  parameter int unsigned LOOKUP_LATENCY = 1,
  parameter int unsigned CNT_W          = 3
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [1:0]  req_valid_i,
  input  logic [2:0]  req_colour0_i,
  input  logic [2:0]  req_colour1_i,
  output logic [1:0]  req_ready_o,
  output logic [1:0]  rsp_valid_o,
  input  logic [1:0]  rsp_ready_i,
  output logic [23:0] rsp_rgb_o,
  output logic        busy_o,
  output logic [2:0]  conv_colour_o,
  output logic        conv_enable_o,
  input  logic [23:0] conv_rgb_i
);

  typedef enum logic [1:0] {StIdle, StLookup, StResp} state_e;

  state_e             state_q, state_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [2:0]         colour_q, colour_d;
  logic               id_q, id_d;
  logic               last_grant_q, last_grant_d;
  logic [23:0]        rsp_rgb_q, rsp_rgb_d;

  logic               gnt_valid;
  logic               gnt_id;

  // Round-robin pick: on contention the requester that was not served last wins.
  always_comb begin
    gnt_valid = 1'b0;
    gnt_id    = 1'b0;
    case (req_valid_i)
      2'b01: begin
        gnt_valid = 1'b1;
        gnt_id    = 1'b0;
      end
      2'b10: begin
        gnt_valid = 1'b1;
        gnt_id    = 1'b1;
      end
      2'b11: begin
        gnt_valid = 1'b1;
        gnt_id    = ~last_grant_q;
      end
      default: ;
    endcase
  end

  // State and datapath registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= StIdle;
      cnt_q        <= '0;
      colour_q     <= '0;
      id_q         <= 1'b0;
      last_grant_q <= 1'b1;
      rsp_rgb_q    <= '0;
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      colour_q     <= colour_d;
      id_q         <= id_d;
      last_grant_q <= last_grant_d;
      rsp_rgb_q    <= rsp_rgb_d;
    end
  end

  // Next-state logic.
  always_comb begin
    state_d      = state_q;
    cnt_d        = cnt_q;
    colour_d     = colour_q;
    id_d         = id_q;
    last_grant_d = last_grant_q;
    rsp_rgb_d    = rsp_rgb_q;
    unique case (state_q)
      StIdle: begin
        if (gnt_valid) begin
          state_d      = StLookup;
          colour_d     = gnt_id ? req_colour1_i : req_colour0_i;
          id_d         = gnt_id;
          last_grant_d = gnt_id;
          cnt_d        = CNT_W'(LOOKUP_LATENCY);
        end
      end
      StLookup: begin
        // Counter runs LOOKUP_LATENCY..0, so the window is LOOKUP_LATENCY+1 cycles and the
        // converter output is valid during the final one.
        if (cnt_q == '0) begin
          rsp_rgb_d = conv_rgb_i;
          state_d   = StResp;
        end else begin
          cnt_d = cnt_q - CNT_W'(1);
        end
      end
      StResp: begin
        if (rsp_ready_i[id_q]) begin
          state_d = StIdle;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  // Outputs.
  always_comb begin
    req_ready_o   = 2'b00;
    rsp_valid_o   = 2'b00;
    conv_enable_o = 1'b0;
    unique case (state_q)
      StIdle: begin
        if (gnt_valid) begin
          req_ready_o = gnt_id ? 2'b10 : 2'b01;
        end
      end
      StLookup: conv_enable_o = 1'b1;
      StResp:   rsp_valid_o   = id_q ? 2'b10 : 2'b01;
      default: ;
    endcase
  end

  assign busy_o        = (state_q != StIdle);
  assign conv_colour_o = colour_q;
  assign rsp_rgb_o     = rsp_rgb_q;

endmodule
